// File: rtl/mac_pkg.sv
// Shared types and width/saturation helpers for the MAC accumulate stage.
package mac_pkg;

    typedef enum logic {
        S_ACC,
        S_OUT
    } state_e;

    function automatic int accw(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

    function automatic longint sat_hi(input int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    function automatic longint sat_lo(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/sat_shift.sv
// Arithmetic right shift (floor) then signed clamp to OW bits.
module sat_shift
    import mac_pkg::*;
#(
    parameter int IW    = 20,
    parameter int OW    = 10,
    parameter int SHIFT = 4
) (
    input  logic signed [IW-1:0] d_i,
    output logic signed [OW-1:0] q_o,
    output logic                 ovf_o
);

    localparam logic signed [IW-1:0] HI = IW'(sat_hi(OW));
    localparam logic signed [IW-1:0] LO = IW'(sat_lo(OW));

    logic signed [IW-1:0] sh;

    assign sh = d_i >>> SHIFT;

    always_comb begin
        q_o   = sh[OW-1:0];
        ovf_o = 1'b0;
        if (sh > HI) begin
            q_o   = HI[OW-1:0];
            ovf_o = 1'b1;
        end else if (sh < LO) begin
            q_o   = LO[OW-1:0];
            ovf_o = 1'b1;
        end
    end

endmodule

// File: rtl/mac_accum.sv
// Signed N-term multiply-accumulate with rescale/saturate, valid/ready in and out.
module mac_accum
    import mac_pkg::*;
#(
    parameter int a     = 10,
    parameter int DW    = 8,
    parameter int N     = 9,
    parameter int SHIFT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_x,
    input  logic signed [DW-1:0] in_w,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [a-1:0]  d_out,
    output logic                 ovf
);

    localparam int ACCW = accw(DW, N);
    localparam int CW   = $clog2(N + 1);

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [a-1:0]    dout_q, dout_d;
    logic                   ovf_q, ovf_d;
    logic                   ov_q, ov_d;

    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] base;
    logic signed [ACCW-1:0] sum;
    logic signed [a-1:0]    sat;
    logic                   sat_ovf;
    logic                   last;

    assign prod = in_x * in_w;
    // First beat of a result starts from zero so no residue carries over.
    assign base = (cnt_q == '0) ? '0 : acc_q;
    assign sum  = base + ACCW'(prod);
    assign last = (cnt_q == CW'(N - 1));

    sat_shift #(
        .IW   (ACCW),
        .OW   (a),
        .SHIFT(SHIFT)
    ) u_sat (
        .d_i  (sum),
        .q_o  (sat),
        .ovf_o(sat_ovf)
    );

    assign in_ready  = (state_q == S_ACC);
    assign out_valid = ov_q;
    assign d_out     = dout_q;
    assign ovf       = ovf_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dout_d  = dout_q;
        ovf_d   = ovf_q;
        ov_d    = ov_q;
        unique case (state_q)
            S_ACC: begin
                if (in_valid) begin
                    acc_d = sum;
                    if (last) begin
                        cnt_d   = '0;
                        dout_d  = sat;
                        ovf_d   = sat_ovf;
                        ov_d    = 1'b1;
                        state_d = S_OUT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = S_ACC;
                end
            end
            default: state_d = S_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_ACC;
            cnt_q   <= '0;
            acc_q   <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            ov_q    <= ov_d;
        end
    end

endmodule

// File: tb/tb_mac_accum.sv
// Randomized and directed bench for mac_accum with a behavioural scoreboard.
module tb_mac_accum;

    localparam int A  = 10;
    localparam int DW = 8;
    localparam int N  = 9;
    localparam int SH = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_x;
    logic signed [DW-1:0] in_w;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [A-1:0]  d_out;
    logic                 ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int or_mode = 0;

    mac_accum #(.a(A), .DW(DW), .N(N), .SHIFT(SH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_w     (in_w),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .d_out    (d_out),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: sum products, floor-divide by 2^SH, clamp to A-bit signed.
    longint m_sum;
    int     m_cnt;
    bit     m_busy;
    longint m_d;
    longint m_ovf;
    bit     rstchk;

    function automatic longint floor_div(input longint v, input longint d);
        longint q;
        q = v / d;
        if ((v % d != 0) && (v < 0)) q = q - 1;
        return q;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            m_sum  = 0;
            m_cnt  = 0;
            m_busy = 0;
            rstchk = 1;
        end else begin
            if (rstchk) begin
                chk("rst_d_out", longint'(d_out), 0);
                chk("rst_ovf", longint'(ovf), 0);
                rstchk = 0;
            end
            chk("in_ready", longint'(in_ready), longint'(!m_busy));
            chk("out_valid", longint'(out_valid), longint'(m_busy));
            if (m_busy) begin
                chk("sb_d_out", longint'(d_out), m_d);
                chk("sb_ovf", longint'(ovf), m_ovf);
                if (out_ready) m_busy = 0;
            end else if (in_valid) begin
                m_sum = m_sum + longint'(in_x) * longint'(in_w);
                m_cnt++;
                if (m_cnt == N) begin
                    m_d   = floor_div(m_sum, longint'(1) << SH);
                    m_ovf = 0;
                    if (m_d > 511) begin
                        m_d   = 511;
                        m_ovf = 1;
                    end else if (m_d < -512) begin
                        m_d   = -512;
                        m_ovf = 1;
                    end
                    m_busy = 1;
                    m_sum  = 0;
                    m_cnt  = 0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic beat(input logic signed [DW-1:0] x,
                        input logic signed [DW-1:0] w,
                        input int gap);
        bit took;
        took = 0;
        repeat (gap) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_x     = x;
        in_w     = w;
        for (int t = 0; t < 200; t++) begin
            bit acc;
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                took = 1;
                break;
            end
        end
        if (!took) chk("beat_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input longint ed,
                               input longint eo);
        bit got;
        got = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1;
                break;
            end
        end
        if (!got) chk({tag, "_timeout"}, 0, 1);
        chk({tag, "_d"}, longint'(d_out), ed);
        chk({tag, "_ovf"}, longint'(ovf), eo);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_x     = '0;
        in_w     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < N; i++) beat(8'sd16, 8'sd1, 0);
        wait_result("sum144", 9, 0);

        for (int i = 0; i < N; i++) beat(8'sd127, 8'sd127, 0);
        wait_result("pos_sat", 511, 1);

        for (int i = 0; i < N; i++) beat(-8'sd128, 8'sd127, 0);
        wait_result("neg_sat", -512, 1);

        beat(-8'sd1, 8'sd1, 0);
        for (int i = 1; i < N; i++) beat(8'sd0, 8'sd0, 2);
        wait_result("floor", -1, 0);

        or_mode = 1;
        for (int i = 0; i < N; i++) beat(8'sd16, 8'sd1, 0);
        in_valid = 1'b1;
        in_x     = 8'sd100;
        in_w     = 8'sd100;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        or_mode  = 0;
        wait_result("held", 9, 0);
        for (int i = 0; i < N; i++) beat(8'sd1, 8'sd16, 0);
        wait_result("no_residue", 9, 0);

        for (int i = 0; i < 4; i++) beat(8'sd50, 8'sd50, 0);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < N; i++) beat(8'sd16, 8'sd1, 0);
        wait_result("after_rst", 9, 0);

        or_mode = 2;
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N; i++)
                beat(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
        end
        or_mode = 0;
        repeat (6) @(posedge clk);
        chk("drained", longint'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_accum.md
# mac_accum

Signed multiply-accumulate stage that sits directly upstream of the ReLU activation. It consumes a stream of N activation/weight pairs through a valid/ready handshake, accumulates their products at full precision, then rescales and saturates the sum to the a-bit signed width the ReLU expects. It presents one result per N accepted pairs and holds that result until the downstream stage takes it.

## Interface
- a, 10, output width in bits (signed); equals the ReLU data width
- DW, 8, signed operand width of in_x and in_w
- N, 9, products per result (3x3 kernel)
- SHIFT, 4, arithmetic right shift applied to the sum before saturation
- clk  input  1  sole clock; all state updates on the rising edge
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept a pair
- in_x  input  DW  signed activation
- in_w  input  DW  signed weight
- out_valid  output  1  d_out/ovf valid
- out_ready  input  1  downstream accepts the result
- d_out  output  a  signed, saturated result, feeds the ReLU d_in
- ovf  output  1  saturation occurred for this result

## Operation
- Internal accumulator width ACCW = 2*DW + clog2(N) (20 at defaults), so no intermediate overflow.
- Two states: S_ACC and S_OUT.
- S_ACC: in_ready=1. A beat is accepted when in_valid && in_ready. On an accepted beat: acc <= (cnt==0 ? 0 : acc) + in_x*in_w (full signed product), cnt <= cnt+1. Cycles with in_valid=0 change nothing.
- On the Nth accepted beat: the final sum is shifted (acc >>> SHIFT, floor rounding) and saturated to [-2^(a-1), 2^(a-1)-1]. The result is registered into d_out, with ovf=1 if clamping occurred. out_valid <= 1, cnt <= 0, state -> S_OUT.
- S_OUT: in_ready=0. Beats offered are not accepted. d_out, ovf and out_valid stay stable until out_valid && out_ready. On that edge out_valid <= 0 and state -> S_ACC.
- Each result is independent; no partial sum carries across results.
- Reset (rst_n=0 at an edge): state=S_ACC, cnt=0, acc=0, out_valid=0, d_out=0, ovf=0. A partial accumulation or an unconsumed result is discarded. in_valid is ignored on any edge where rst_n=0.

## Timing
- in_ready is combinational from state only. It is 1 in the first cycle after reset deasserts.
- Latency: out_valid rises on the edge after the Nth beat is accepted.
- Minimum period per result is N+1 cycles (N beats, plus 1 S_OUT cycle with out_ready=1).
- out_valid, d_out and ovf are registered. There is no combinational path from in_* or out_ready to any output except in_ready, which depends on state only.
- Backpressure may last any number of cycles with no data loss.

## Structure
- Shared package mac_pkg holds:
  - the state encoding (S_ACC, S_OUT)
  - the ACCW derivation
  - the saturation bounds as functions of a
- One natural sub-module, sat_shift: combinational block that performs the ACCW-bit arithmetic shift by SHIFT, clamps to a bits and flags ovf. It is reusable by later stages (pooling, bias-add).
- cnt width is clog2(N+1).

## Test plan
- 9 beats in_x=16, in_w=1, back-to-back, out_ready=1 -> acc=144, d_out=9, ovf=0; out_valid high exactly one cycle, on the edge after beat 9.
- 9 beats in_x=127, in_w=127 -> sum 145161, shifted 9072 -> d_out=511, ovf=1.
- 9 beats in_x=-128, in_w=127 -> sum -146304, shifted -9144 -> d_out=-512 (0x200), ovf=1.
- Beat 1 in_x=-1, in_w=1, then 8 beats of zeros, with in_valid bubbles between beats -> d_out=-1 (0x3FF), proving floor rounding; bubbles are not counted.
- Hold out_ready=0 for 5 cycles while driving in_valid=1 -> in_ready=0, d_out/ovf/out_valid stable, no beats absorbed. After the handshake, the next 9 beats of in_x=1, in_w=16 -> d_out=9, with no residue from the prior result.
- Pulse rst_n=0 for 1 cycle after 4 accepted beats -> all outputs 0, in_ready=1 the next cycle. A fresh 9 beats of in_x=16, in_w=1 -> d_out=9.
